// File: rtl/dmem_access_unit_pkg.sv
// Purpose: shared CPU definitions for the data-memory access path (func3 codes, FSM states, lane helpers).
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package dmem_access_unit_pkg;

  // RV32I load/store width codes carried in func3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Byte lanes touched by an access; halfwords ignore addr[0] so lanes stay naturally aligned
  function automatic logic [3:0] byte_en_for(input logic [2:0] func3, input logic [1:0] offset);
    logic [3:0] be;
    case (func3[1:0])
      2'b00:   be = 4'b0001 << offset;
      2'b01:   be = 4'b0011 << {offset[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data copied into every lane so the byte enables alone pick the target bytes
  function automatic logic [31:0] replicate_store(input logic [2:0] func3, input logic [31:0] data);
    logic [31:0] rep;
    case (func3[1:0])
      2'b00:   rep = {4{data[7:0]}};
      2'b01:   rep = {2{data[15:0]}};
      default: rep = data;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/dmem_access_unit_load_extender.sv
// Purpose: pick the addressed byte/halfword out of a memory word and sign/zero extend it.
// Latency: purely combinational.
// Backpressure: none.
module load_extender
  import dmem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  func3,
  input  logic [1:0]  offset,
  output logic [31:0] result
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;

  assign byte_shift = word >> {offset, 3'b000};
  assign half_shift = word >> {offset[1], 4'b0000};

  // Select lane and apply the extension implied by func3
  always_comb begin
    result = word;
    case (func3)
      F3_B:    result = {{24{byte_shift[7]}}, byte_shift[7:0]};
      F3_BU:   result = {24'd0, byte_shift[7:0]};
      F3_H:    result = {{16{half_shift[15]}}, half_shift[15:0]};
      F3_HU:   result = {16'd0, half_shift[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Purpose: MEM-stage load/store sequencer (IDLE/ACCESS/DONE) with byte lanes, extension and timeout.
// Latency: request to STALL release >= 2 cycles; bus error after MAX_WAIT ACCESS cycles.
// Backpressure: STALL holds the pipeline while busy; DMEM_BUSY extends ACCESS. Option: DMEM_MISALIGN_TRAP_EN.
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  MEM_FUNC3,
  input  logic [31:0] MEM_ADDR,
  input  logic [31:0] MEM_WRITE_DATA,
  input  logic [31:0] DMEM_READ_DATA,
  input  logic        DMEM_BUSY,
  output logic        DMEM_READ,
  output logic        DMEM_WRITE,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WRITE_DATA,
  output logic [3:0]  DMEM_BYTE_EN,
  output logic [31:0] MEM_DATA_MEM_READ_DATA,
  output logic        STALL,
  output logic        BUS_ERROR
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic        MISALIGNED
`endif
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [1:0]       state_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [2:0]       func3_q;
  logic             store_q;
  logic [31:0]      ext_word;
  logic             req;
  logic             trap;
  logic             last_wait;
  logic             finish;

  assign req       = MEM_READ | MEM_WRITE;
  assign last_wait = (wait_cnt_q == CNT_W'(MAX_WAIT - 1));
  // A ready memory wins over a simultaneous timeout
  assign finish    = !DMEM_BUSY || last_wait;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = ((MEM_FUNC3[1:0] == 2'b01) && MEM_ADDR[0]) ||
                ((MEM_FUNC3[1:0] == 2'b10) && (MEM_ADDR[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  assign DMEM_ADDR       = {addr_q[31:2], 2'b00};
  assign DMEM_WRITE_DATA = replicate_store(func3_q, wdata_q);

  load_extender u_load_extender (
    .word   (DMEM_READ_DATA),
    .func3  (func3_q),
    .offset (addr_q[1:0]),
    .result (ext_word)
  );

  // Capture the request while it is accepted in IDLE
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr_q  <= '0;
      wdata_q <= '0;
      func3_q <= '0;
      store_q <= 1'b0;
    end else if (state_q == ST_IDLE && req) begin
      addr_q  <= MEM_ADDR;
      wdata_q <= MEM_WRITE_DATA;
      func3_q <= MEM_FUNC3;
      store_q <= MEM_WRITE;
    end
  end

  // Sequencer: state, wait counter and registered memory strobes
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      DMEM_READ    <= 1'b0;
      DMEM_WRITE   <= 1'b0;
      DMEM_BYTE_EN <= 4'b0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            if (trap) begin
              state_q <= ST_DONE;
            end else begin
              state_q      <= ST_ACCESS;
              wait_cnt_q   <= '0;
              DMEM_READ    <= !MEM_WRITE;
              DMEM_WRITE   <= MEM_WRITE;
              DMEM_BYTE_EN <= byte_en_for(MEM_FUNC3, MEM_ADDR[1:0]);
            end
          end
        end
        ST_ACCESS: begin
          if (finish) begin
            state_q      <= ST_DONE;
            DMEM_READ    <= 1'b0;
            DMEM_WRITE   <= 1'b0;
            DMEM_BYTE_EN <= 4'b0000;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Result and error are loaded on entry to DONE and held until the next DONE
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      MEM_DATA_MEM_READ_DATA <= '0;
      BUS_ERROR              <= 1'b0;
    end else if (state_q == ST_IDLE && req && trap) begin
      MEM_DATA_MEM_READ_DATA <= '0;
      BUS_ERROR              <= 1'b0;
    end else if (state_q == ST_ACCESS && finish) begin
      BUS_ERROR              <= DMEM_BUSY;
      MEM_DATA_MEM_READ_DATA <= (DMEM_BUSY || store_q) ? 32'd0 : ext_word;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  // Misalignment flag is high exactly for the DONE cycle of a trapped access
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      MISALIGNED <= 1'b0;
    end else if (state_q == ST_IDLE && req && trap) begin
      MISALIGNED <= 1'b1;
    end else if (state_q == ST_DONE) begin
      MISALIGNED <= 1'b0;
    end
  end
`endif

  // Stall while a request waits in IDLE or memory is being accessed
  always_comb begin
    STALL = 1'b0;
    if (!RESET) begin
      case (state_q)
        ST_IDLE:   STALL = req;
        ST_ACCESS: STALL = 1'b1;
        default:   STALL = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
module tb_dmem_access_unit;
  import dmem_access_unit_pkg::*;

  localparam int MAXW = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        MEM_READ = 1'b0;
  logic        MEM_WRITE = 1'b0;
  logic [2:0]  MEM_FUNC3 = 3'b000;
  logic [31:0] MEM_ADDR = '0;
  logic [31:0] MEM_WRITE_DATA = '0;
  logic [31:0] DMEM_READ_DATA = '0;
  logic        DMEM_BUSY = 1'b0;
  logic        DMEM_READ;
  logic        DMEM_WRITE;
  logic [31:0] DMEM_ADDR;
  logic [31:0] DMEM_WRITE_DATA;
  logic [3:0]  DMEM_BYTE_EN;
  logic [31:0] MEM_DATA_MEM_READ_DATA;
  logic        STALL;
  logic        BUS_ERROR;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        MISALIGNED;
`endif

  int checks = 0;
  int errors = 0;

  dmem_access_unit #(.MAX_WAIT(MAXW)) dut (
    .CLK                    (CLK),
    .RESET                  (RESET),
    .MEM_READ               (MEM_READ),
    .MEM_WRITE              (MEM_WRITE),
    .MEM_FUNC3              (MEM_FUNC3),
    .MEM_ADDR               (MEM_ADDR),
    .MEM_WRITE_DATA         (MEM_WRITE_DATA),
    .DMEM_READ_DATA         (DMEM_READ_DATA),
    .DMEM_BUSY              (DMEM_BUSY),
    .DMEM_READ              (DMEM_READ),
    .DMEM_WRITE             (DMEM_WRITE),
    .DMEM_ADDR              (DMEM_ADDR),
    .DMEM_WRITE_DATA        (DMEM_WRITE_DATA),
    .DMEM_BYTE_EN           (DMEM_BYTE_EN),
    .MEM_DATA_MEM_READ_DATA (MEM_DATA_MEM_READ_DATA),
    .STALL                  (STALL),
    .BUS_ERROR              (BUS_ERROR)
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    .MISALIGNED             (MISALIGNED)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Reference model: expected lanes, store data, load result and error from the access rules
  function automatic void model(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rdat, input int busy,
                                output logic [31:0] res, output logic [3:0] be,
                                output logic [31:0] wdo, output logic err);
    int off;
    int o;
    logic [31:0] lane;
    off = int'(a[1:0]);
    if (f3[1:0] == 2'b00) begin
      be   = 4'(1 << off);
      lane = (rdat >> (8 * off)) & 32'h0000_00FF;
      wdo  = {24'd0, wd[7:0]} * 32'h0101_0101;
      res  = (!f3[2] && lane >= 32'd128) ? lane - 32'd256 : lane;
    end else if (f3[1:0] == 2'b01) begin
      o    = (off / 2) * 2;
      be   = 4'(3 << o);
      lane = (rdat >> (8 * o)) & 32'h0000_FFFF;
      wdo  = {16'd0, wd[15:0]} * 32'h0001_0001;
      res  = (!f3[2] && lane >= 32'd32768) ? lane - 32'd65536 : lane;
    end else begin
      be   = 4'hF;
      wdo  = wd;
      res  = rdat;
    end
    err = (busy >= MAXW);
    if (wr || err) res = 32'd0;
  endfunction

  // One complete access: IDLE request, ACCESS with busy_n busy cycles, DONE, then a held-value cycle
  task automatic run_txn(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                         input int busy_n, input logic [31:0] exp_res, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input logic exp_err);
    int stalls;
    int exp_stalls;
    bit done;
    stalls = 0;
    done = 0;
    exp_stalls = 1 + ((busy_n >= MAXW) ? MAXW : busy_n + 1);
    @(negedge CLK);
    MEM_READ = rd; MEM_WRITE = wr; MEM_FUNC3 = f3; MEM_ADDR = a; MEM_WRITE_DATA = wd;
    DMEM_READ_DATA = rdat; DMEM_BUSY = 1'b1;
    #1;
    check({nm, " idle stall"}, {63'd0, STALL}, 64'd1);
    stalls = 1;
    for (int k = 1; k <= MAXW + 3 && !done; k++) begin
      @(negedge CLK);
      DMEM_BUSY = (k <= busy_n);
      #1;
      if (STALL) begin
        stalls++;
        check({nm, " access req"}, {26'd0, DMEM_READ, DMEM_WRITE, DMEM_ADDR, DMEM_BYTE_EN},
              {26'd0, !wr, wr, a & 32'hFFFF_FFFC, exp_be});
        if (wr) check({nm, " store data"}, {32'd0, DMEM_WRITE_DATA}, {32'd0, exp_wd});
      end else begin
        done = 1;
        check({nm, " done result"}, {31'd0, BUS_ERROR, MEM_DATA_MEM_READ_DATA}, {31'd0, exp_err, exp_res});
        check({nm, " done strobes"}, {62'd0, DMEM_READ, DMEM_WRITE}, 64'd0);
        MEM_READ = 1'b0; MEM_WRITE = 1'b0; DMEM_BUSY = 1'b0; DMEM_READ_DATA = ~rdat;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s timeout: STALL still %0d after %0d cycles, required release", nm, STALL, MAXW + 3);
      MEM_READ = 1'b0; MEM_WRITE = 1'b0; DMEM_BUSY = 1'b0;
    end
    check({nm, " stall cycles"}, 64'(stalls), 64'(exp_stalls));
    @(negedge CLK);
    #1;
    check({nm, " held"}, {30'd0, STALL, BUS_ERROR, MEM_DATA_MEM_READ_DATA}, {30'd0, 1'b0, exp_err, exp_res});
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdat;
    int          busy;
    logic [31:0] res;
    logic [3:0]  be;
    logic [31:0] wdo;
    logic        err;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [31:0] m_res;
    logic [3:0]  m_be;
    logic [31:0] m_wd;
    logic        m_err;
    logic        r_rd;
    logic        r_wr;
    logic [2:0]  r_f3;
    logic [31:0] r_a;
    logic [31:0] r_wd;
    logic [31:0] r_rdat;
    int          r_busy;
    logic [2:0]  ld_codes[5];
    logic [2:0]  st_codes[3];

    tbl[0]  = '{1'b1, 1'b0, F3_W,  32'h100, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 1'b0, F3_B,  32'h103, 32'h0,        32'h80112233, 1, 32'hFFFFFF80, 4'h8, 32'h0,        1'b0};
    tbl[2]  = '{1'b1, 1'b0, F3_BU, 32'h103, 32'h0,        32'h80112233, 0, 32'h00000080, 4'h8, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 1'b1, F3_H,  32'h202, 32'h0000ABCD, 32'h0,        0, 32'h0,        4'hC, 32'hABCDABCD, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, F3_H,  32'h102, 32'h0,        32'h80011234, 2, 32'hFFFF8001, 4'hC, 32'h0,        1'b0};
    tbl[5]  = '{1'b1, 1'b0, F3_HU, 32'h100, 32'h0,        32'h1234F00D, 0, 32'h0000F00D, 4'h3, 32'h0,        1'b0};
    tbl[6]  = '{1'b0, 1'b1, F3_B,  32'h301, 32'hFFFFFF55, 32'h0,        3, 32'h0,        4'h2, 32'h55555555, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, F3_W,  32'h400, 32'h12345678, 32'h0,        1, 32'h0,        4'hF, 32'h12345678, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, F3_W,  32'h104, 32'h0,        32'hCAFEF00D, 9, 32'h0,        4'hF, 32'h0,        1'b1};
    tbl[9]  = '{1'b1, 1'b0, F3_B,  32'h000, 32'h0,        32'h0000007F, 0, 32'h0000007F, 4'h1, 32'h0,        1'b0};
    tbl[10] = '{1'b1, 1'b1, F3_W,  32'h010, 32'h11223344, 32'h0,        0, 32'h0,        4'hF, 32'h11223344, 1'b0};

    ld_codes = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    st_codes = '{F3_B, F3_H, F3_W};

    // Reset state, with a request present to show STALL is forced low
    MEM_READ = 1'b1;
    #2;
    check("reset strobes", {60'd0, DMEM_READ, DMEM_WRITE, BUS_ERROR, STALL}, 64'd0);
    check("reset result", {28'd0, DMEM_BYTE_EN, MEM_DATA_MEM_READ_DATA}, 64'd0);
    MEM_READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 11; i++)
      run_txn($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].wd,
              tbl[i].rdat, tbl[i].busy, tbl[i].res, tbl[i].be, tbl[i].wdo, tbl[i].err);

`ifndef DMEM_MISALIGN_TRAP_EN
    // Misaligned halfword/word accesses drop the offending low address bits
    run_txn("lh_mis", 1'b1, 1'b0, F3_H, 32'h101, 32'h0, 32'hAABBCCDD, 0, 32'hFFFFCCDD, 4'h3, 32'h0, 1'b0);
    run_txn("lw_mis", 1'b1, 1'b0, F3_W, 32'h103, 32'h0, 32'h01020304, 1, 32'h01020304, 4'hF, 32'h0, 1'b0);
`else
    // Trapped misaligned word load: straight to DONE, no strobe
    @(negedge CLK);
    MEM_READ = 1'b1; MEM_FUNC3 = F3_W; MEM_ADDR = 32'h102; DMEM_BUSY = 1'b0;
    #1;
    check("mis idle", {62'd0, STALL, DMEM_READ}, 64'd2);
    @(negedge CLK);
    #1;
    check("mis done", {29'd0, STALL, DMEM_READ, MISALIGNED, MEM_DATA_MEM_READ_DATA}, {29'd0, 3'b001, 32'd0});
    MEM_READ = 1'b0;
    @(negedge CLK);
    #1;
    check("mis cleared", {62'd0, MISALIGNED, STALL}, 64'd0);
`endif

    // Request still present in DONE: return to IDLE and stall again without a strobe
    @(negedge CLK);
    MEM_READ = 1'b1; MEM_WRITE = 1'b0; MEM_FUNC3 = F3_W; MEM_ADDR = 32'h600; DMEM_READ_DATA = 32'h5A5A0F0F;
    DMEM_BUSY = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("hold done", {31'd0, STALL, MEM_DATA_MEM_READ_DATA}, {31'd0, 1'b0, 32'h5A5A0F0F});
    @(negedge CLK);
    #1;
    check("hold reidle", {62'd0, STALL, DMEM_READ}, 64'd2);
    MEM_READ = 1'b0;
    @(negedge CLK);
    #1;
    check("hold idle", {62'd0, STALL, DMEM_READ}, 64'd0);

    // Reset in the second ACCESS cycle
    @(negedge CLK);
    MEM_READ = 1'b1; MEM_FUNC3 = F3_W; MEM_ADDR = 32'h500; DMEM_BUSY = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("rst pre", {62'd0, DMEM_READ, STALL}, 64'd3);
    RESET = 1'b1;
    #1;
    check("rst async", {58'd0, DMEM_READ, DMEM_WRITE, DMEM_BYTE_EN}, 64'd0);
    check("rst stall", {63'd0, STALL}, 64'd0);
    MEM_READ = 1'b0; DMEM_BUSY = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    #1;
    check("rst idle", {62'd0, DMEM_READ, STALL}, 64'd0);
    run_txn("post_rst", 1'b1, 1'b0, F3_HU, 32'h702, 32'h0, 32'hBEEF1234, 0, 32'h0000BEEF, 4'hC, 32'h0, 1'b0);

    // Randomized accesses against the reference model
    for (int n = 0; n < 40; n++) begin
      r_wr = $urandom_range(0, 1);
      r_rd = r_wr ? 1'($urandom_range(0, 1)) : 1'b1;
      r_f3 = r_wr ? st_codes[$urandom_range(0, 2)] : ld_codes[$urandom_range(0, 4)];
      r_a = $urandom;
`ifdef DMEM_MISALIGN_TRAP_EN
      if (r_f3[1:0] == 2'b01) r_a[0] = 1'b0;
      if (r_f3[1:0] == 2'b10) r_a[1:0] = 2'b00;
`endif
      r_wd = $urandom;
      r_rdat = $urandom;
      r_busy = $urandom_range(0, MAXW + 1);
      model(r_wr, r_f3, r_a, r_wd, r_rdat, r_busy, m_res, m_be, m_wd, m_err);
      run_txn($sformatf("rnd%0d", n), r_rd, r_wr, r_f3, r_a, r_wd, r_rdat, r_busy, m_res, m_be, m_wd, m_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255: maximum cycles spent in ACCESS before a bus error is declared.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port MEM_READ, input, 1 bit: MEM-stage load request.
REQ-005 SHALL have port MEM_WRITE, input, 1 bit: MEM-stage store request.
REQ-006 SHALL have port MEM_FUNC3, input, 3 bits: RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 SHALL have port MEM_ADDR, input, 32 bits: byte address from the ALU.
REQ-008 SHALL have port MEM_WRITE_DATA, input, 32 bits: store data, right-aligned.
REQ-009 SHALL have ports DMEM_READ_DATA (input, 32) and DMEM_BUSY (input, 1): memory response word and memory busy flag.
REQ-010 SHALL have ports DMEM_READ (output, 1), DMEM_WRITE (output, 1), DMEM_ADDR (output, 32), DMEM_WRITE_DATA (output, 32) and DMEM_BYTE_EN (output, 4): the memory request.
REQ-011 SHALL have ports MEM_DATA_MEM_READ_DATA (output, 32), STALL (output, 1) and BUS_ERROR (output, 1): extended load result, pipeline stall, and timeout flag.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-013 SHALL, in IDLE with MEM_READ or MEM_WRITE high, drive STALL=1 combinationally, latch the request, and move to ACCESS on the next edge.
REQ-014 SHALL hold DMEM_READ or DMEM_WRITE high, from registers, for every ACCESS cycle; never both.
REQ-015 SHALL drive DMEM_ADDR = {latched addr[31:2], 2'b00}.
REQ-016 SHALL set DMEM_BYTE_EN to 0001<<addr[1:0] for B, 0011<<{addr[1],0} for H, and 1111 for W.
REQ-017 SHALL drive DMEM_WRITE_DATA with the store data replicated across lanes: byte x4 for B, half x2 for H.
REQ-018 SHALL leave ACCESS for DONE on the first edge at which DMEM_BUSY=0, provided ACCESS has lasted at least one full cycle; on a load it captures DMEM_READ_DATA at that edge.
REQ-019 SHALL count ACCESS cycles; when the count reaches MAX_WAIT, move to DONE with BUS_ERROR=1 and a load result of 0.
REQ-020 SHALL, in DONE, drive STALL=0, present MEM_DATA_MEM_READ_DATA, and return to IDLE on the next edge, even if a request is still present.
REQ-021 SHALL extract the load lane using addr[1:0]: sign-extended for B/H, zero-extended for BU/HU, unchanged for W; store results are 0.
REQ-022 SHALL hold MEM_DATA_MEM_READ_DATA and BUS_ERROR registered from DONE until the next DONE.
REQ-023 SHALL give minimum latency from request to STALL release of 2 cycles (IDLE, ACCESS, DONE).
REQ-024 SHALL treat MEM_READ and MEM_WRITE both high as a store.

Reset
REQ-025 SHALL, on RESET high and independent of CLK, force state IDLE, counter 0, DMEM_READ/DMEM_WRITE/BUS_ERROR 0, MEM_DATA_MEM_READ_DATA 0, DMEM_BYTE_EN 0 and STALL 0.
REQ-026 SHALL, on reset mid-ACCESS, drop the strobes immediately and start no new access until RESET falls and a request is seen in IDLE.

Configuration
REQ-027 SHALL, with DMEM_MISALIGN_TRAP_EN defined, detect a misaligned H (addr[0]=1) or W (addr[1:0]!=0) access and then go IDLE->DONE with no strobe, drive output MISALIGNED=1 for the DONE cycle, and return a load result of 0.
REQ-028 SHALL, without DMEM_MISALIGN_TRAP_EN, omit the MISALIGNED port and force naturally aligned lanes by ignoring the offending low address bits.

Structure
REQ-029 SHALL place the FUNC3 width codes and the FSM state encodings in the shared CPU package.
REQ-030 SHALL implement lane extraction and sign/zero extension in a combinational sub-module load_extender.

Verification
REQ-031 SHALL cover: LW from 0x100, BUSY low after 1 cycle, data 0xDEADBEEF -> STALL high 2 cycles, result 0xDEADBEEF.
REQ-032 SHALL cover: LB from 0x103 with word 0x80112233 -> result 0xFFFFFF80; LBU from the same address -> 0x00000080.
REQ-033 SHALL cover: SH of 0x0000ABCD to 0x202 -> DMEM_BYTE_EN 1100, DMEM_WRITE_DATA 0xABCDABCD, DMEM_ADDR 0x200.
REQ-034 SHALL cover: BUSY held high with MAX_WAIT=4 -> DONE after 4 ACCESS cycles, BUS_ERROR 1, result 0.
REQ-035 SHALL cover: RESET asserted in the second ACCESS cycle -> strobes and STALL 0 the same timestep, IDLE afterward.
REQ-036 SHALL cover, with the macro defined: LW at 0x102 -> no DMEM_READ, MISALIGNED 1 for one cycle, STALL 1 for one cycle.
